// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase scheduler: phase encodings,
// default durations and the per-approach light triple with its decoders.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_MAIN_GREEN  = 3'd0,
    PH_MAIN_YELLOW = 3'd1,
    PH_CLEAR_A     = 3'd2,
    PH_SIDE_GREEN  = 3'd3,
    PH_SIDE_YELLOW = 3'd4,
    PH_CLEAR_B     = 3'd5,
    PH_PED_WALK    = 3'd6
  } phase_t;

  localparam int DEF_MAIN_GREEN_MIN = 15;
  localparam int DEF_SIDE_GREEN     = 10;
  localparam int DEF_YELLOW         = 5;
  localparam int DEF_ALL_RED        = 2;
  localparam int DEF_WALK           = 8;
  localparam int DEF_CNT_W          = 8;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } light_t;

  localparam light_t LIGHT_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
  localparam light_t LIGHT_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
  localparam light_t LIGHT_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

  // Anything that is not an active main phase shows red, including the illegal code.
  function automatic light_t main_lights(input phase_t ph);
    case (ph)
      PH_MAIN_GREEN:  return LIGHT_GREEN;
      PH_MAIN_YELLOW: return LIGHT_YELLOW;
      default:        return LIGHT_RED;
    endcase
  endfunction

  function automatic light_t side_lights(input phase_t ph);
    case (ph)
      PH_SIDE_GREEN:  return LIGHT_GREEN;
      PH_SIDE_YELLOW: return LIGHT_YELLOW;
      default:        return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter: loadable, with equality and at-or-past compares against a
// terminal value, and optional saturation at all-ones.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             sat_en,
  input  logic [CNT_W-1:0] tc_value,
  output logic [CNT_W-1:0] count,
  output logic             tc_hit,
  output logic             tc_reached
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (!(sat_en && (&count_reg))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count      = count_reg;
  assign tc_hit     = (count_reg == tc_value);
  assign tc_reached = (count_reg >= tc_value);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-approach intersection sequencer with an optional pedestrian walk phase,
// built only when INTERSECTION_PED_EN is defined.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN_MIN = DEF_MAIN_GREEN_MIN,
  parameter int SIDE_GREEN     = DEF_SIDE_GREEN,
  parameter int YELLOW         = DEF_YELLOW,
  parameter int ALL_RED        = DEF_ALL_RED,
  parameter int WALK           = DEF_WALK,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] MG_TC = CNT_W'(MAIN_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] SG_TC = CNT_W'(SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_TC  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_TC = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] W_TC  = CNT_W'(WALK - 1);

  phase_t           state_reg, state_next;
  logic [CNT_W-1:0] tc_value, count;
  logic             tc_hit, tc_reached;
  logic             ped_pending;
  light_t           main_l, side_l;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (state_next != state_reg),
    .load_value ('0),
    .sat_en     (state_reg == PH_MAIN_GREEN),
    .tc_value   (tc_value),
    .count      (count),
    .tc_hit     (tc_hit),
    .tc_reached (tc_reached)
  );

`ifdef INTERSECTION_PED_EN
  logic ped_pending_reg;
  logic walk_entry;

  // Entering the walk serves every request seen so far, including one on this edge.
  assign walk_entry = (state_next == PH_PED_WALK) && (state_reg != PH_PED_WALK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ped_pending_reg <= 1'b0;
    end else if (walk_entry) begin
      ped_pending_reg <= 1'b0;
    end else if (ped_req) begin
      ped_pending_reg <= 1'b1;
    end
  end

  assign ped_pending = ped_pending_reg;
  assign walk        = (state_reg == PH_PED_WALK);
  assign ped_ack     = (state_reg == PH_PED_WALK) && (count == '0);
`else
  logic ped_req_unused;
  logic count_unused;

  assign ped_req_unused = ped_req;
  assign count_unused   = |count;
  assign ped_pending    = 1'b0;
  assign walk           = 1'b0;
  assign ped_ack        = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= PH_CLEAR_B;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    tc_value   = '0;
    state_next = state_reg;
    case (state_reg)
      PH_MAIN_GREEN: begin
        tc_value = MG_TC;
        if (tc_reached && (side_req || ped_pending)) state_next = PH_MAIN_YELLOW;
      end
      PH_MAIN_YELLOW: begin
        tc_value = Y_TC;
        if (tc_hit) state_next = PH_CLEAR_A;
      end
      PH_CLEAR_A: begin
        tc_value = AR_TC;
        if (tc_hit) state_next = ped_pending ? PH_PED_WALK : PH_SIDE_GREEN;
      end
      PH_SIDE_GREEN: begin
        tc_value = SG_TC;
        if (tc_hit) state_next = PH_SIDE_YELLOW;
      end
      PH_SIDE_YELLOW: begin
        tc_value = Y_TC;
        if (tc_hit) state_next = PH_CLEAR_B;
      end
      PH_CLEAR_B: begin
        tc_value = AR_TC;
        if (tc_hit) state_next = PH_MAIN_GREEN;
      end
`ifdef INTERSECTION_PED_EN
      PH_PED_WALK: begin
        tc_value = W_TC;
        if (tc_hit) state_next = side_req ? PH_SIDE_GREEN : PH_CLEAR_B;
      end
`endif
      // Illegal encodings fall back to a safe all-red clearance.
      default: state_next = PH_CLEAR_B;
    endcase
  end

  assign main_l = main_lights(state_reg);
  assign side_l = side_lights(state_reg);

  assign main_red    = main_l.red;
  assign main_yellow = main_l.yellow;
  assign main_green  = main_l.green;
  assign side_red    = side_l.red;
  assign side_yellow = side_l.yellow;
  assign side_green  = side_l.green;
  assign phase       = state_reg;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: stimulus queues per-cycle expected phases/lights, a
// negedge monitor pops and compares. Pedestrian tests need INTERSECTION_PED_EN.
module tb_intersection_phase_scheduler;

  logic       clock;
  logic       reset_n;
  logic       side_req;
  logic       ped_req;
  logic       main_red, main_yellow, main_green;
  logic       side_red, side_yellow, side_green;
  logic       walk, ped_ack;
  logic [2:0] phase;

  intersection_phase_scheduler dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .side_req    (side_req),
    .ped_req     (ped_req),
    .main_red    (main_red),
    .main_yellow (main_yellow),
    .main_green  (main_green),
    .side_red    (side_red),
    .side_yellow (side_yellow),
    .side_green  (side_green),
    .walk        (walk),
    .ped_ack     (ped_ack),
    .phase       (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [10:0] vec;   // phase, main r/y/g, side r/y/g, walk, ped_ack
    int          tid;
    int          idx;
  } exp_t;

  exp_t q[$];
  int   test_id;
  int   push_idx;
  int   n_tests;
  int   n_fail;
  logic mon_en;
  logic drain_chk;

  function automatic logic [5:0] lights(input int ph);
    case (ph)
      0:       return {3'b001, 3'b100};
      1:       return {3'b010, 3'b100};
      3:       return {3'b100, 3'b001};
      4:       return {3'b100, 3'b010};
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  task automatic push(input int ph, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.vec = {3'(ph), lights(ph), (ph == 6) ? 1'b1 : 1'b0, (ph == 6 && i == 0) ? 1'b1 : 1'b0};
      e.tid = test_id;
      e.idx = push_idx;
      push_idx++;
      q.push_back(e);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic reset_pulse(input int n_low);
    reset_n = 1'b0;
    push(5, n_low);
    run(n_low);
    reset_n = 1'b1;
  endtask

  task automatic new_test(input int id);
    test_id  = id;
    push_idx = 0;
  endtask

  always @(negedge clock) begin
    logic [10:0] act;
    exp_t        e;
    act = {phase, main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk, ped_ack};
    if (mon_en) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL underflow: no expectation queued, got phase=%0d", phase);
      end else begin
        e = q.pop_front();
        if (act !== e.vec) begin
          n_fail++;
          $display("FAIL test%0d cycle%0d: got ph=%0d lights=%b walk=%b ack=%b, expected ph=%0d lights=%b walk=%b ack=%b",
                   e.tid, e.idx, act[10:8], act[7:2], act[1], act[0],
                   e.vec[10:8], e.vec[7:2], e.vec[1], e.vec[0]);
        end
      end
    end else if (drain_chk) begin
      n_tests++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
    end
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    mon_en    = 1'b0;
    drain_chk = 1'b0;
    test_id   = 0;
    push_idx  = 0;
    reset_n   = 1'b0;
    side_req  = 1'b0;
    ped_req   = 1'b0;

    // Idle main road: CLEAR_B 2 then main green for 200 cycles.
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    new_test(1);
    push(5, 2);
    push(0, 200);
    run(202);
    $display("[TB] test1 idle main road done");

    // Side request held through two full side cycles.
    new_test(2);
    side_req = 1'b1;
    push(0, 1);
    push(1, 5); push(2, 2); push(3, 10); push(4, 5); push(5, 2);
    push(0, 15);
    push(1, 5); push(2, 2); push(3, 10); push(4, 5); push(5, 2);
    run(64);
    $display("[TB] test2 side request only done");

    // Short side request inside the main minimum must not preempt.
    new_test(3);
    side_req = 1'b0;
    push(0, 40);
    run(3);
    side_req = 1'b1;
    run(8);
    side_req = 1'b0;
`ifdef INTERSECTION_PED_EN
    run(29);
`else
    run(9);
    ped_req = 1'b1;
    run(1);
    ped_req = 1'b0;
    run(19);
`endif
    $display("[TB] test3 short side request done");

`ifdef INTERSECTION_PED_EN
    // Pedestrian only: pulse at main-green cycle 3.
    new_test(4);
    reset_pulse(2);
    push(5, 2);
    push(0, 15); push(1, 5); push(2, 2); push(6, 8); push(5, 2);
    push(0, 10);
    run(5);
    ped_req = 1'b1;
    run(1);
    ped_req = 1'b0;
    run(38);
    $display("[TB] test4 pedestrian only done");

    // Pedestrian plus side, with a second press during the walk.
    new_test(5);
    side_req = 1'b1;
    ped_req  = 1'b1;
    push(0, 5); push(1, 5); push(2, 2); push(6, 8); push(3, 10); push(4, 5); push(5, 2);
    push(0, 15); push(1, 5); push(2, 2); push(6, 8); push(3, 10); push(4, 5); push(5, 2);
    push(0, 20);
    run(1);
    ped_req = 1'b0;
    run(14);
    ped_req = 1'b1;
    run(1);
    ped_req = 1'b0;
    run(68);
    side_req = 1'b0;
    run(20);
    $display("[TB] test5 pedestrian plus side done");
`endif

    // Reset mid side green with a pedestrian press pending.
    new_test(6);
    side_req = 1'b1;
    push(0, 1); push(1, 5); push(2, 2); push(3, 4);
    run(8);
    ped_req = 1'b1;
    run(1);
    ped_req = 1'b0;
    run(3);
    side_req = 1'b0;
    reset_pulse(2);
    push(5, 2);
    push(0, 30);
    run(32);
    $display("[TB] test6 reset mid-operation done");

    mon_en    = 1'b0;
    drain_chk = 1'b1;
    @(negedge clock);
    #1;
    drain_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Sequences a two-approach intersection (main road, side road) plus an optional pedestrian walk phase. Each approach gets its own red/yellow/green outputs, and the two approaches are never green together. The block sits above the per-signal light drivers and shares the crossing between three requesters: main-road traffic (the default owner), the side-road vehicle sensor, and the pedestrian push-button.

## Interface
- MAIN_GREEN_MIN, default 15: minimum main-green cycles before a request can preempt it.
- SIDE_GREEN, default 10: side-green cycles.
- YELLOW, default 5: yellow cycles on either approach.
- ALL_RED, default 2: all-red clearance cycles.
- WALK, default 8: pedestrian walk cycles.
- CNT_W, default 8: phase counter width. Every duration must be ≥1 and ≤2**CNT_W−1.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- side_req  input  1  side-road vehicle present; level signal, not latched.
- ped_req  input  1  pedestrian button; single-cycle pulse, latched internally.
- main_red, main_yellow, main_green  output  1 each  main-road lights, one-hot.
- side_red, side_yellow, side_green  output  1 each  side-road lights, one-hot.
- walk  output  1  pedestrian walk lamp.
- ped_ack  output  1  one-cycle pulse in the first cycle of PED_WALK.
- phase  output  3  current state encoding.

## Operation
- States and encodings:
  - MAIN_GREEN = 0
  - MAIN_YELLOW = 1
  - CLEAR_A = 2
  - SIDE_GREEN = 3
  - SIDE_YELLOW = 4
  - CLEAR_B = 5
  - PED_WALK = 6
  - Encoding 7 is illegal and recovers to CLEAR_B on the next edge.
- Phase counter:
  - Cleared to 0 on every state change; otherwise increments by 1.
  - A timed state of duration N exits when the counter equals N−1, so it lasts exactly N cycles.
- State transitions:
  - **MAIN_GREEN:** once counter ≥ MAIN_GREEN_MIN−1 and (side_req or ped_pending), go to MAIN_YELLOW. Otherwise hold indefinitely; the counter saturates at all-ones.
  - **MAIN_YELLOW:** after YELLOW cycles, go to CLEAR_A.
  - **CLEAR_A:** after ALL_RED cycles, go to PED_WALK if ped_pending, else SIDE_GREEN.
  - **PED_WALK:** after WALK cycles, go to SIDE_GREEN if side_req is high in the final cycle, else CLEAR_B.
  - **SIDE_GREEN:** after SIDE_GREEN cycles, go to SIDE_YELLOW.
  - **SIDE_YELLOW:** after YELLOW cycles, go to CLEAR_B.
  - **CLEAR_B:** after ALL_RED cycles, go to MAIN_GREEN.
- ped_pending latch:
  - Set by ped_req in any cycle.
  - Cleared on the edge that enters PED_WALK. If set and clear occur on the same edge, clear wins, because that request is served by this walk.
  - ped_req arriving during PED_WALK or later is held and served on the next cycle of phases.
- Outputs are Moore, decoded from the state register:
  - In CLEAR_A, CLEAR_B and PED_WALK, both approaches show red.
  - walk = 1 only in PED_WALK.
- Reset (asynchronous, any time, including mid-phase):
  - state = CLEAR_B, counter = 0, ped_pending = 0.
  - main_red = side_red = 1; all other light outputs = 0.
  - walk = 0, ped_ack = 0, phase = 5.

## Timing
- Inputs are sampled on the rising clock edge. The state changes on the edge after the exit condition is seen; outputs follow in the same cycle as the new state.
- side_req has no latency beyond one edge. A side_req that drops before the MAIN_GREEN minimum elapses is ignored.
- ped_ack is high for exactly one cycle: the first cycle of PED_WALK.
- After reset_n deasserts: CLEAR_B for ALL_RED cycles, then MAIN_GREEN.
- Default full side cycle, from the MAIN_YELLOW entry back to MAIN_GREEN: 5 + 2 + 10 + 5 + 2 = 24 cycles.

## Configuration
- INTERSECTION_PED_EN defined: pedestrian phase present, behaving as described above.
- INTERSECTION_PED_EN undefined:
  - ped_req is ignored, and the ped_pending latch and PED_WALK logic are not built.
  - walk and ped_ack are tied to 0.
  - CLEAR_A always goes to SIDE_GREEN, and MAIN_GREEN exits only on side_req.
  - All ports remain present.

## Structure
- Shared package traffic_pkg:
  - phase_t enum with the encodings above.
  - Default duration localparams.
  - A light-triple struct.
- One natural sub-module, phase_timer: loadable counter with a terminal-count compare and a saturate option, instanced once.

## Test plan
- **Idle main road:** reset, no requests.
  - Expect CLEAR_B for 2 cycles, then MAIN_GREEN.
  - main_green stays 1 for 200 cycles; phase = 0.
- **Side request only:** side_req held high.
  - Expect MAIN_GREEN 15, MAIN_YELLOW 5, CLEAR_A 2, SIDE_GREEN 10, SIDE_YELLOW 5, CLEAR_B 2 cycles.
  - main_green and side_green are never both 1.
- **Short side request:** side_req high for main-green cycles 3–10 only, then low.
  - Expect no exit from MAIN_GREEN.
- **Pedestrian only:** with INTERSECTION_PED_EN defined and no side_req, a ped_req pulse at main-green cycle 3.
  - Expect yellow from cycle 15, then CLEAR_A 2, then PED_WALK 8 with walk = 1 and ped_ack pulsing on its first cycle.
  - Then CLEAR_B, then MAIN_GREEN.
- **Pedestrian plus side:** side_req held, ped_req pulse once before the walk and again during PED_WALK.
  - Expect PED_WALK, then SIDE_GREEN.
  - The second request causes another PED_WALK on the next cycle of phases.
  - With INTERSECTION_PED_EN undefined, walk stays 0 throughout.
- **Reset mid-operation:** reset_n pulsed low mid SIDE_GREEN with ped_pending set.
  - Expect immediate phase = 5, both approaches red, and no walk afterward without a new ped_req.
